// File: rtl/qmath_pkg.sv
// Shared sign-magnitude Q-format definitions used by the fixed-point datapath blocks.
package qmath_pkg;

    localparam int Q_DEFAULT = 15;
    localparam int N_DEFAULT = 32;

    localparam logic SIGN_POS = 1'b0;
    localparam logic SIGN_NEG = 1'b1;

    // Largest representable magnitude of an n-bit sign-magnitude word: n-1 ones.
    function automatic logic [63:0] mag_max(input int n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

endpackage

// File: rtl/qaddsub_pipe_if.sv
// Operand/result handshake bundle for qaddsub_pipe; master drives operands, slave is the adder.
interface qaddsub_pipe_if import qmath_pkg::*; #(parameter int N = N_DEFAULT);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] c;
    logic         ovf;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, c, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, c, ovf
    );

endinterface

// File: rtl/qaddsub_core.sv
// Combinational sign-magnitude add/subtract on pre-normalised operands, with saturation and overflow.
module qaddsub_core import qmath_pkg::*; #(
    parameter int Q   = Q_DEFAULT,
    parameter int N   = N_DEFAULT,
    parameter bit SAT = 1'b1
) (
    input  logic [N-2:0] a_mag,
    input  logic [N-2:0] b_mag,
    input  logic         a_sign,
    input  logic         b_sign,
    input  logic         a_ge_b,
    input  logic         same_sign,
    output logic [N-1:0] c,
    output logic         ovf
);

    localparam logic [N-2:0] MAG_ALL = (N-1)'(mag_max(N));

    generate
        if (N < Q + 2) begin : g_bad_format
            $error("qaddsub_core: N must be at least Q+2");
        end
    endgenerate

    logic [N-1:0] sum;
    logic [N-2:0] mag;
    logic         sign;

    always_comb begin
        sum  = {1'b0, a_mag} + {1'b0, b_mag};
        ovf  = 1'b0;
        mag  = '0;
        sign = SIGN_POS;
        if (same_sign) begin
            ovf  = sum[N-1];
            mag  = (ovf && SAT) ? MAG_ALL : sum[N-2:0];
            sign = a_sign;
        end else if (a_ge_b) begin
            mag  = a_mag - b_mag;
            sign = a_sign;
        end else begin
            mag  = b_mag - a_mag;
            sign = b_sign;
        end
        // A zero magnitude (cancellation or wrap) is always reported as +0.
        if (mag == '0) begin
            sign = SIGN_POS;
        end
        c = {sign, mag};
    end

endmodule

// File: rtl/qaddsub_pipe.sv
// Two-stage valid/ready sign-magnitude adder/subtractor with global stall and sticky overflow.
module qaddsub_pipe import qmath_pkg::*; #(
    parameter int Q   = Q_DEFAULT,
    parameter int N   = N_DEFAULT,
    parameter bit SAT = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    qaddsub_pipe_if.slave  bus,
    output logic           ovf_sticky,
    input  logic           clr_sticky
);

    logic         adv;
    logic [N-2:0] a_mag_in;
    logic [N-2:0] b_mag_in;

    logic         s1_valid_q, s1_valid_d;
    logic [N-2:0] s1_a_mag_q, s1_a_mag_d;
    logic [N-2:0] s1_b_mag_q, s1_b_mag_d;
    logic         s1_a_sign_q, s1_a_sign_d;
    logic         s1_b_sign_q, s1_b_sign_d;
    logic         s1_a_ge_b_q, s1_a_ge_b_d;
    logic         s1_same_q, s1_same_d;

    logic         out_valid_q, out_valid_d;
    logic [N-1:0] c_q, c_d;
    logic         ovf_q, ovf_d;
    logic         sticky_q, sticky_d;

    logic [N-1:0] core_c;
    logic         core_ovf;

    always_comb begin
        adv      = !out_valid_q || bus.out_ready;
        a_mag_in = bus.a[N-2:0];
        b_mag_in = bus.b[N-2:0];

        s1_valid_d  = s1_valid_q;
        s1_a_mag_d  = s1_a_mag_q;
        s1_b_mag_d  = s1_b_mag_q;
        s1_a_sign_d = s1_a_sign_q;
        s1_b_sign_d = s1_b_sign_q;
        s1_a_ge_b_d = s1_a_ge_b_q;
        s1_same_d   = s1_same_q;
        if (adv) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                // Signs of zero magnitudes are dropped so -0 behaves exactly like +0.
                s1_a_mag_d  = a_mag_in;
                s1_b_mag_d  = b_mag_in;
                s1_a_sign_d = bus.a[N-1] && (a_mag_in != '0);
                s1_b_sign_d = (bus.b[N-1] ^ bus.sub) && (b_mag_in != '0);
                s1_a_ge_b_d = (a_mag_in >= b_mag_in);
                s1_same_d   = (s1_a_sign_d == s1_b_sign_d);
            end
        end

        out_valid_d = out_valid_q;
        c_d         = c_q;
        ovf_d       = ovf_q;
        if (adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                c_d   = core_c;
                ovf_d = core_ovf;
            end
        end

        sticky_d = sticky_q;
        if (out_valid_q && bus.out_ready && ovf_q) begin
            sticky_d = 1'b1;
        end else if (clr_sticky) begin
            sticky_d = 1'b0;
        end
    end

    qaddsub_core #(
        .Q   (Q),
        .N   (N),
        .SAT (SAT)
    ) u_core (
        .a_mag     (s1_a_mag_q),
        .b_mag     (s1_b_mag_q),
        .a_sign    (s1_a_sign_q),
        .b_sign    (s1_b_sign_q),
        .a_ge_b    (s1_a_ge_b_q),
        .same_sign (s1_same_q),
        .c         (core_c),
        .ovf       (core_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_mag_q  <= '0;
            s1_b_mag_q  <= '0;
            s1_a_sign_q <= 1'b0;
            s1_b_sign_q <= 1'b0;
            s1_a_ge_b_q <= 1'b0;
            s1_same_q   <= 1'b0;
            out_valid_q <= 1'b0;
            c_q         <= '0;
            ovf_q       <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_mag_q  <= s1_a_mag_d;
            s1_b_mag_q  <= s1_b_mag_d;
            s1_a_sign_q <= s1_a_sign_d;
            s1_b_sign_q <= s1_b_sign_d;
            s1_a_ge_b_q <= s1_a_ge_b_d;
            s1_same_q   <= s1_same_d;
            out_valid_q <= out_valid_d;
            c_q         <= c_d;
            ovf_q       <= ovf_d;
            sticky_q    <= sticky_d;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.c         = c_q;
    assign bus.ovf       = ovf_q;
    assign ovf_sticky    = sticky_q;

endmodule

// File: tb/tb_qaddsub_pipe.sv
// Scoreboard bench for qaddsub_pipe: a saturating and a wrapping instance run in lock-step.
module tb_qaddsub_pipe;
    import qmath_pkg::*;

    localparam int N = 32;
    localparam int Q = 15;

    logic clk = 1'b0;
    logic rst;
    logic clr_sticky;
    logic sticky1;
    logic sticky0;

    int total = 0;
    int bad   = 0;
    int n_out = 0;

    logic [N:0] q1[$];
    logic [N:0] q0[$];
    logic [N:0] exp1;
    logic [N:0] exp0;

    always #5 clk = ~clk;

    qaddsub_pipe_if #(.N(N)) bus ();
    qaddsub_pipe_if #(.N(N)) bus0 ();

    assign bus0.in_valid  = bus.in_valid;
    assign bus0.a         = bus.a;
    assign bus0.b         = bus.b;
    assign bus0.sub       = bus.sub;
    assign bus0.out_ready = bus.out_ready;

    qaddsub_pipe #(.Q(Q), .N(N), .SAT(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .ovf_sticky (sticky1),
        .clr_sticky (clr_sticky)
    );

    qaddsub_pipe #(.Q(Q), .N(N), .SAT(1'b0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus0.slave),
        .ovf_sticky (sticky0),
        .clr_sticky (clr_sticky)
    );

    // Reference: signed integer arithmetic, then clamp or truncate the magnitude.
    function automatic logic [N:0] model(input logic [N-1:0] av, input logic [N-1:0] bv,
                                         input logic sv, input bit sat);
        longint ma, mb, va, vb, r, m, mx;
        logic sg, ov;
        mx = (longint'(1) << (N - 1)) - 1;
        ma = longint'(av[N-2:0]);
        mb = longint'(bv[N-2:0]);
        va = av[N-1] ? -ma : ma;
        vb = (bv[N-1] ^ sv) ? -mb : mb;
        r  = va + vb;
        m  = (r < 0) ? -r : r;
        ov = (m > mx);
        if (ov) m = sat ? mx : (m & mx);
        sg = (r < 0) && (m != 0);
        return {ov, sg, m[N-2:0]};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q1.delete();
            q0.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                total++;
                if (q1.size() == 0) begin
                    bad++;
                    $display("FAIL sb_sat unexpected result got=%h", bus.c);
                end else begin
                    exp1 = q1.pop_front();
                    if ({bus.ovf, bus.c} !== exp1)
                        begin bad++; $display("FAIL sb_sat got ovf=%b c=%h exp ovf=%b c=%h", bus.ovf, bus.c, exp1[N], exp1[N-1:0]); end
                end
            end
            if (bus0.out_valid && bus0.out_ready) begin
                total++;
                if (q0.size() == 0) begin
                    bad++;
                    $display("FAIL sb_wrap unexpected result got=%h", bus0.c);
                end else begin
                    exp0 = q0.pop_front();
                    if ({bus0.ovf, bus0.c} !== exp0)
                        begin bad++; $display("FAIL sb_wrap got ovf=%b c=%h exp ovf=%b c=%h", bus0.ovf, bus0.c, exp0[N], exp0[N-1:0]); end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q1.push_back(model(bus.a, bus.b, bus.sub, 1'b1));
                q0.push_back(model(bus.a, bus.b, bus.sub, 1'b0));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N-1:0] av, input logic [N-1:0] bv, input logic sv);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.a = av;
        bus.b = bv;
        bus.sub = sv;
        for (int w = 0; w < 50 && !ok; w++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin total++; bad++; $display("FAIL send_timeout got=not_accepted exp=accepted"); end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((q1.size() != 0 || bus.out_valid) && w < 100) begin
            tick();
            w++;
        end
        total++;
        if (q1.size() != 0 || q0.size() != 0 || bus.out_valid !== 1'b0)
            begin bad++; $display("FAIL drain pending=%0d/%0d exp=0/0", q1.size(), q0.size()); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr_sticky = 1'b0;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.sub = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.c !== 32'h0) begin bad++; $display("FAIL rst_c got=%h exp=0", bus.c); end
        total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", bus.ovf); end
        total++; if (sticky1 !== 1'b0) begin bad++; $display("FAIL rst_sticky got=%b exp=0", sticky1); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_add();
        send(32'h0000_8000, 32'h0000_C000, 1'b0);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL add_latency_early got=%b exp=0", bus.out_valid); end
        tick();
        total++;
        if (bus.out_valid !== 1'b1 || bus.c !== 32'h0001_4000 || bus.ovf !== 1'b0)
            begin bad++; $display("FAIL add_result got v=%b c=%h o=%b exp v=1 c=00014000 o=0", bus.out_valid, bus.c, bus.ovf); end
        drain();
    endtask

    task automatic test_sub();
        send(32'h0000_8000, 32'h0000_C000, 1'b1);
        send(32'h0000_8000, 32'h8000_8000, 1'b0);
        total++; if (bus.c !== 32'h8000_4000) begin bad++; $display("FAIL sub_negative got=%h exp=80004000", bus.c); end
        tick();
        total++; if (bus.c !== 32'h0000_0000) begin bad++; $display("FAIL sub_cancel got=%h exp=00000000", bus.c); end
        drain();
    endtask

    task automatic test_overflow();
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        tick();
        total++; if (bus.c !== 32'h7FFF_FFFF || bus.ovf !== 1'b1) begin bad++; $display("FAIL ovf_sat got c=%h o=%b exp c=7fffffff o=1", bus.c, bus.ovf); end
        total++; if (bus0.c !== 32'h0 || bus0.ovf !== 1'b1) begin bad++; $display("FAIL ovf_wrap got c=%h o=%b exp c=00000000 o=1", bus0.c, bus0.ovf); end
        tick();
        total++; if (sticky1 !== 1'b1 || sticky0 !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b%b exp=11", sticky1, sticky0); end
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        tick();
        total++; if (bus.c !== 32'hFFFF_FFFF || bus.ovf !== 1'b1) begin bad++; $display("FAIL ovf_neg_sat got c=%h o=%b exp c=ffffffff o=1", bus.c, bus.ovf); end
        drain();
    endtask

    task automatic test_sticky();
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        total++; if (sticky1 !== 1'b0) begin bad++; $display("FAIL sticky_clear got=%b exp=0", sticky1); end
        bus.out_ready = 1'b0;
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        tick();
        total++; if (bus.out_valid !== 1'b1 || bus.ovf !== 1'b1 || sticky1 !== 1'b0)
            begin bad++; $display("FAIL sticky_pending got v=%b o=%b s=%b exp v=1 o=1 s=0", bus.out_valid, bus.ovf, sticky1); end
        clr_sticky = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        clr_sticky = 1'b0;
        total++; if (sticky1 !== 1'b1) begin bad++; $display("FAIL sticky_set_wins got=%b exp=1", sticky1); end
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        total++; if (sticky1 !== 1'b0) begin bad++; $display("FAIL sticky_clear2 got=%b exp=0", sticky1); end
        drain();
    endtask

    task automatic test_back_to_back();
        int base;
        base = n_out;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send($urandom, $urandom, 1'($urandom_range(0, 1)));
            end
            begin
                logic [N-1:0] cap;
                logic         cap_o;
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                cap   = bus.c;
                cap_o = bus.ovf;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    total++;
                    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.c !== cap || bus.ovf !== cap_o)
                        begin bad++; $display("FAIL stall_hold got r=%b v=%b c=%h exp r=0 v=1 c=%h", bus.in_ready, bus.out_valid, bus.c, cap); end
                    @(posedge clk);
                end
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        total++; if (n_out - base != 6) begin bad++; $display("FAIL b2b_count got=%0d exp=6", n_out - base); end
    endtask

    task automatic test_reset_midflight();
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        drain();
        total++; if (sticky1 !== 1'b1) begin bad++; $display("FAIL mid_pre_sticky got=%b exp=1", sticky1); end
        send(32'h0000_8000, 32'h0000_C000, 1'b0);
        send(32'h0000_1234, 32'h0000_0000, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (bus.out_valid !== 1'b0 || sticky1 !== 1'b0 || bus0.out_valid !== 1'b0)
            begin bad++; $display("FAIL mid_reset got v=%b s=%b exp v=0 s=0", bus.out_valid, sticky1); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_stale cycle=%0d got=%b exp=0", i, bus.out_valid); end
        end
        send(32'h0000_8000, 32'h0000_8000, 1'b0);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_latency_early got=%b exp=0", bus.out_valid); end
        tick();
        total++; if (bus.out_valid !== 1'b1 || bus.c !== 32'h0001_0000)
            begin bad++; $display("FAIL mid_next got v=%b c=%h exp v=1 c=00010000", bus.out_valid, bus.c); end
        drain();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_sticky();
        test_back_to_back();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
